spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-requester arbiter and sequencer in front of the single-port `spram` framebuffer (8-bit words, 1-cycle registered read). Port A is the display scanout reader and has priority; port B is the general read/write port used by the waterfall line writer and host. The block registers the SPRAM command and tags in-flight reads so each port gets its own `rvalid`-qualified data. A starvation counter guarantees B forward progress. Out-of-range accesses are suppressed and flagged.

## Interface
- `DATA_W`, 8, data width
- `ADDR_W`, 17, address width
- `DEPTH`, 49152, number of valid addresses; `addr >= DEPTH` is out of range
- `STARVE_LIMIT`, 8, consecutive B-wait cycles before B overrides A; legal range 1..255

- `clk` in 1: single clock, all logic on posedge
- `reset_n` in 1: asynchronous, active-low reset
- `a_req` in 1: A read request, held with `a_addr` stable until granted
- `a_addr` in ADDR_W: A read address
- `a_gnt` out 1: A request accepted this cycle
- `a_rvalid` out 1: `a_rdata` valid this cycle
- `a_rdata` out DATA_W: A read data
- `b_req` in 1: B request, held with `b_we`/`b_addr`/`b_wdata` stable until granted
- `b_we` in 1: 1 = write, 0 = read
- `b_addr` in ADDR_W: B address
- `b_wdata` in DATA_W: B write data
- `b_gnt` out 1: B request accepted this cycle
- `b_rvalid` out 1: `b_rdata` valid this cycle
- `b_rdata` out DATA_W: B read data
- `err` out 1: one-cycle pulse, out-of-range access issued
- `mem_addr` out ADDR_W: to spram `addr`, registered
- `mem_w_data` out DATA_W: to spram `w_data`, registered
- `mem_w_en` out 1: to spram `w_en`, registered
- `mem_r_data` in DATA_W: from spram `r_data`

## Operation
- Arbitration is combinational on the current cycle. One grant at most per cycle.
  - Default: `a_gnt = a_req`; `b_gnt = b_req & ~a_req`.
  - Override: if `starve_cnt == STARVE_LIMIT` and `b_req`, then `b_gnt = 1` and `a_gnt = 0`.
- `starve_cnt` (8-bit):
  - Increments (saturating at `STARVE_LIMIT`) on cycles with `b_req & ~b_gnt`.
  - Clears on `b_gnt` or `~b_req`.
- Issue stage (registered at the posedge ending the grant cycle):
  - `mem_addr` ← granted address.
  - `mem_w_data` ← `b_wdata`.
  - `mem_w_en` ← `b_gnt & b_we & in_range`.
  - With no grant: `mem_w_en` ← 0; `mem_addr`/`mem_w_data` hold.
- Read tag pipeline, 2 stages: {valid, port, oor}.
  - Stage 1 is loaded from the grant of a read.
  - Stage 2 lines up with `mem_r_data`.
  - `x_rvalid` = stage-2 valid & port==x.
  - `x_rdata` = oor ? 0 : `mem_r_data` when `x_rvalid`, else 0.
- Out of range (`addr >= DEPTH`):
  - The request is still granted. Writes never assert `mem_w_en`; reads return 0 with `rvalid`.
  - `err` pulses in the issue cycle (grant+1).
- `gnt` is forced to 0 while `reset_n` is low.

## Timing
- Reset values: `a_gnt`, `b_gnt`, `a_rvalid`, `b_rvalid`, `err`, `mem_w_en` = 0. `a_rdata`, `b_rdata`, `mem_addr`, `mem_w_data` = 0. `starve_cnt` = 0. Tag pipeline cleared.
- Grant in cycle N:
  - Command on `mem_*` in N+1.
  - Write is committed at the end of N+1.
  - Read data and `rvalid` arrive in N+2.
  - Throughput is one access per cycle total.
- Read-after-write: a B write granted in N followed by any read of the same address granted in N+1 returns the new data.
- Simultaneous A and B requests with `starve_cnt < STARVE_LIMIT`: A wins and B's counter increments.
- Sustained dual requests produce STARVE_LIMIT A grants, then 1 B grant, repeating.
- Reset mid-operation discards in-flight reads: no `rvalid` after release until new grants. Any write not yet committed is dropped.
- A requester that drops `req` before grant is simply not served. No state is kept.

## Test plan
- Reset: hold `reset_n` low with `a_req`=`b_req`=1 → every output 0. First grant (`a_gnt`) in the first cycle after release.
- A read: preload addr 5 = 0x3C; `a_req` at N → `a_gnt` at N, `mem_addr`=5 at N+1, `a_rvalid`=1 and `a_rdata`=0x3C at N+2, `b_rvalid`=0 throughout.
- B write then read: write 0x77 to addr 100 granted at N, read addr 100 granted at N+1 → `mem_w_en`=1 at N+1 only, `b_rvalid`=1 and `b_rdata`=0x77 at N+3.
- Starvation: `a_req` and `b_req` held high, STARVE_LIMIT=8 → `a_gnt` for 8 cycles, `b_gnt` on the 9th, then the pattern repeats. Exactly one grant per cycle.
- Out of range: B write 0xFF to addr 49152 → `b_gnt`=1, `mem_w_en` stays 0, `err`=1 at N+1. B read of addr 60000 → `b_rvalid`=1 with `b_rdata`=0 at N+2, and `err` pulses.
- Reset mid-read: A read granted at N, `reset_n` low during N+1 → `a_rvalid` never asserts for that read; `mem_w_en`=0.

Source files
------------

// File: rtl/spram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port framebuffer SPRAM.
// Port A (scanout) has priority; a starvation counter guarantees port B progress.
module spram_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 17,
  parameter int DEPTH        = 49152,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      LIMIT   = 8'(STARVE_LIMIT);
  localparam logic            PORT_A  = 1'b0;

  typedef struct packed {
    logic valid;
    logic port;
    logic oor;
  } tag_t;

  logic [7:0]        starve_cnt;
  logic              override;
  logic              a_in_range;
  logic              b_in_range;
  logic              gnt_any;
  logic              gnt_read;
  logic              gnt_oor;
  logic [ADDR_W-1:0] gnt_addr;
  tag_t              tag_s1;
  tag_t              tag_s2;

  // Handshake: a requester raises req and holds its command stable; gnt in the
  // same cycle means the command is taken at the next posedge. Dropping req
  // before gnt withdraws the request. Read data returns two cycles after gnt,
  // qualified by that port's rvalid.
  assign override   = (starve_cnt == LIMIT) && b_req;
  assign a_gnt      = reset_n && a_req && !override;
  assign b_gnt      = reset_n && b_req && (!a_req || override);
  assign a_in_range = {1'b0, a_addr} < DEPTH_X;
  assign b_in_range = {1'b0, b_addr} < DEPTH_X;

  assign gnt_any  = a_gnt | b_gnt;
  assign gnt_read = a_gnt | (b_gnt & ~b_we);
  assign gnt_addr = b_gnt ? b_addr : a_addr;
  assign gnt_oor  = b_gnt ? !b_in_range : !a_in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (b_req && !b_gnt) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      mem_w_data <= '0;
      mem_w_en   <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (gnt_any) begin
        mem_addr   <= gnt_addr;
        mem_w_data <= b_wdata;
      end
      mem_w_en <= b_gnt && b_we && b_in_range;
      err      <= gnt_any && gnt_oor;
    end
  end

  // Stage 2 lines up with the SPRAM's registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1 <= '{valid: gnt_read, port: b_gnt, oor: gnt_oor};
      tag_s2 <= tag_s1;
    end
  end

  assign a_rvalid = tag_s2.valid && (tag_s2.port == PORT_A);
  assign b_rvalid = tag_s2.valid && (tag_s2.port != PORT_A);
  assign a_rdata  = (a_rvalid && !tag_s2.oor) ? mem_r_data : '0;
  assign b_rdata  = (b_rvalid && !tag_s2.oor) ? mem_r_data : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Randomised scoreboard bench for spram_arbiter with a behavioural SPRAM and
// a transaction-level reference model (shadow memory + wait counter).
module tb_spram_arbiter;
  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 17;
  localparam int DEPTH        = 49152;
  localparam int STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              a_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic              a_gnt, a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req = 1'b0;
  logic              b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_gnt, b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_r_data = '0;

  spram_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata), .err(err),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en), .mem_r_data(mem_r_data)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural SPRAM (garbage outside the array) ----------------
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (int'(mem_addr) < DEPTH) begin
      mem_r_data <= ram[mem_addr];
      if (mem_w_en) ram[mem_addr] <= mem_w_data;
    end else begin
      mem_r_data <= 8'hA5;
    end
  end

  // ---------------- reference model state / scoreboard ----------------
  typedef struct {
    int                due;
    logic              w_en;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  int                errors = 0;
  int                checks = 0;
  int                wait_cnt = 0;
  logic [DATA_W-1:0] shadow [int];
  cmd_t              cmd_q [$];
  logic [DATA_W-1:0] a_exp_q [$];
  logic [DATA_W-1:0] b_exp_q [$];
  int                a_due_q [$];
  int                b_due_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] shadow_rd(input int addr);
    return shadow.exists(addr) ? shadow[addr] : '0;
  endfunction

  // ---------------- driver: one call = one clock cycle of stimulus ----------------
  task automatic drive(input logic rst, input logic ar, input logic [ADDR_W-1:0] aa,
                       input logic br, input logic bw, input logic [ADDR_W-1:0] ba,
                       input logic [DATA_W-1:0] bd, output logic ga, output logic gb);
    cmd_t c;
    logic oor;
    logic [ADDR_W-1:0] addr;
    @(negedge clk);
    #1;
    reset_n = rst; a_req = ar; a_addr = aa;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    if (!rst) begin
      ga = 1'b0; gb = 1'b0; wait_cnt = 0;
      cmd_q.delete(); a_exp_q.delete(); b_exp_q.delete(); a_due_q.delete(); b_due_q.delete();
      check("mem_addr_rst", mem_addr, 0);
      check("mem_w_data_rst", mem_w_data, 0);
    end else begin
      gb = br && (!ar || wait_cnt >= STARVE_LIMIT);
      ga = ar && !gb;
      if (br && !gb) wait_cnt = (wait_cnt < STARVE_LIMIT) ? wait_cnt + 1 : wait_cnt;
      else wait_cnt = 0;
    end
    check("a_gnt", a_gnt, ga);
    check("b_gnt", b_gnt, gb);
    if (ga || gb) begin
      addr = gb ? ba : aa;
      oor = int'(addr) >= DEPTH;
      c.due = cyc + 1; c.w_en = gb && bw && !oor; c.err = oor; c.addr = addr; c.wdata = bd;
      cmd_q.push_back(c);
      if (ga) begin
        a_exp_q.push_back(oor ? '0 : shadow_rd(int'(addr)));
        a_due_q.push_back(cyc + 2);
      end else if (!bw) begin
        b_exp_q.push_back(oor ? '0 : shadow_rd(int'(addr)));
        b_due_q.push_back(cyc + 2);
      end else if (!oor) begin
        shadow[int'(addr)] = bd;
      end
    end
  endtask

  task automatic idle(input int n);
    logic ga, gb;
    repeat (n) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
  endtask

  // ---------------- monitor: pops expectations as the DUT presents outputs ----------------
  always @(negedge clk) begin
    cmd_t c;
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      c = cmd_q.pop_front();
      check("mem_w_en", mem_w_en, c.w_en);
      check("err", err, c.err);
      check("mem_addr", mem_addr, c.addr);
      check("mem_w_data", mem_w_data, c.wdata);
    end else begin
      check("mem_w_en_idle", mem_w_en, 0);
      check("err_idle", err, 0);
    end
    if (a_due_q.size() > 0 && a_due_q[0] == cyc) begin
      void'(a_due_q.pop_front());
      check("a_rvalid", a_rvalid, 1);
      check("a_rdata", a_rdata, a_exp_q.pop_front());
    end else begin
      check("a_rvalid_idle", a_rvalid, 0);
      check("a_rdata_idle", a_rdata, 0);
    end
    if (b_due_q.size() > 0 && b_due_q[0] == cyc) begin
      void'(b_due_q.pop_front());
      check("b_rvalid", b_rvalid, 1);
      check("b_rdata", b_rdata, b_exp_q.pop_front());
    end else begin
      check("b_rvalid_idle", b_rvalid, 0);
      check("b_rdata_idle", b_rdata, 0);
    end
  end

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 88) return ADDR_W'($urandom_range(0, 31));
    case (r % 4)
      0:       return ADDR_W'(DEPTH - 1);
      1:       return ADDR_W'(DEPTH);
      2:       return ADDR_W'(60000);
      default: return '1;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic ga, gb;
    logic pa, pb, pbw;
    logic [ADDR_W-1:0] paa, pba;
    logic [DATA_W-1:0] pbd;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    ram[5] = 8'h3C;
    shadow[5] = 8'h3C;

    // Reset held with both requesters active, then first A grant on release.
    repeat (3) drive(1'b0, 1'b1, 17'd7, 1'b1, 1'b0, 17'd9, 8'h00, ga, gb);
    drive(1'b1, 1'b1, 17'd7, 1'b0, 1'b0, '0, '0, ga, gb);
    idle(3);

    // A read of preloaded address.
    drive(1'b1, 1'b1, 17'd5, 1'b0, 1'b0, '0, '0, ga, gb);
    idle(3);

    // B write then read-after-write.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 17'd100, 8'h77, ga, gb);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 17'd100, 8'h00, ga, gb);
    idle(3);

    // Sustained dual requests: starvation override pattern.
    repeat (2 * (STARVE_LIMIT + 1) + 2) drive(1'b1, 1'b1, 17'd5, 1'b1, 1'b0, 17'd100, 8'h00, ga, gb);
    idle(3);

    // Out-of-range accesses.
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 17'd49152, 8'hFF, ga, gb);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 17'd60000, 8'h00, ga, gb);
    drive(1'b1, 1'b1, 17'd131071, 1'b0, 1'b0, '0, '0, ga, gb);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 17'd49151, 8'h00, ga, gb);
    idle(3);

    // Reset during an in-flight read.
    drive(1'b1, 1'b1, 17'd5, 1'b0, 1'b0, '0, '0, ga, gb);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
    idle(4);

    // Randomised traffic; requests held until granted, B occasionally withdraws.
    pa = 1'b0; pb = 1'b0; pbw = 1'b0; paa = '0; pba = '0; pbd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa && $urandom_range(0, 99) < 60) begin
        pa = 1'b1; paa = rand_addr();
      end
      if (!pb && $urandom_range(0, 99) < 50) begin
        pb = 1'b1; pbw = 1'($urandom_range(0, 1)); pba = rand_addr(); pbd = 8'($urandom);
      end else if (pb && $urandom_range(0, 99) < 3) begin
        pb = 1'b0;
      end
      drive(1'b1, pa, paa, pb, pbw, pba, pbd, ga, gb);
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
    end
    idle(5);

    check("cmd_q_drained", cmd_q.size(), 0);
    check("a_q_drained", a_exp_q.size(), 0);
    check("b_q_drained", b_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
